// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, load-type bit indices and the packed layouts of
// the execute->memory and memory->writeback buses, plus extension helpers.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 83;
    localparam int MS_TO_WS_BUS_WD = 73;
    localparam int STALL_BUS_WD    = 10;
    localparam int FORWARD_BUS_WD  = 33;
    localparam int DATA_W          = 32;

    // One-hot inst_load bit positions
    localparam int LD_LW  = 6;
    localparam int LD_LB  = 5;
    localparam int LD_LBU = 4;
    localparam int LD_LH  = 3;
    localparam int LD_LHU = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    typedef struct packed {
        logic              res_from_mem;  // [82]
        logic [6:0]        inst_load;     // [81:75]
        logic [4:0]        ld_extd_op;    // [74:70]
        logic              gr_we;         // [69]
        logic [4:0]        dest;          // [68:64]
        logic [DATA_W-1:0] alu_result;    // [63:32]
        logic [DATA_W-1:0] pc;            // [31:0]
    } es_to_ms_t;

    typedef struct packed {
        logic [3:0]        rf_wen;        // [72:69]
        logic [4:0]        dest;          // [68:64]
        logic [DATA_W-1:0] final_result;  // [63:32]
        logic [DATA_W-1:0] pc;            // [31:0]
    } ms_to_ws_t;

    // Byte to word, sign- or zero-extended
    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [DATA_W-1:0] sx;
        sx = DATA_W'($signed(b));
        return sgn ? sx : {24'b0, b};
    endfunction

    // Halfword to word, sign- or zero-extended
    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [DATA_W-1:0] sx;
        sx = DATA_W'($signed(h));
        return sgn ? sx : {16'b0, h};
    endfunction

endpackage

// File: rtl/mem_stage_ld_align.sv
// mem_stage_ld_align: combinational load-data alignment and extension plus
// per-byte register write strobes (partial strobes for lwl/lwr).
module mem_stage_ld_align
    import mem_stage_pkg::*;
(
    input  logic [6:0]        inst_load,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] rdata,
    input  logic              gr_we,
    output logic [DATA_W-1:0] ld_data,
    output logic [3:0]        rf_wen
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend or shift per load type
    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        ld_data  = rdata;
        rf_wen   = {4{gr_we}};
        case (1'b1)
            inst_load[LD_LW]:  ld_data = rdata;
            inst_load[LD_LB]:  ld_data = ext8(byte_sel, 1'b1);
            inst_load[LD_LBU]: ld_data = ext8(byte_sel, 1'b0);
            inst_load[LD_LH]:  ld_data = ext16(half_sel, 1'b1);
            inst_load[LD_LHU]: ld_data = ext16(half_sel, 1'b0);
            inst_load[LD_LWL]: begin
                // (3-addr)*8 == ~addr*8 for a 2-bit address
                ld_data = rdata << {~addr, 3'b000};
                case (addr)
                    2'd0:    rf_wen = 4'b1000;
                    2'd1:    rf_wen = 4'b1100;
                    2'd2:    rf_wen = 4'b1110;
                    default: rf_wen = 4'b1111;
                endcase
            end
            inst_load[LD_LWR]: begin
                ld_data = rdata >> {addr, 3'b000};
                case (addr)
                    2'd0:    rf_wen = 4'b1111;
                    2'd1:    rf_wen = 4'b0111;
                    2'd2:    rf_wen = 4'b0011;
                    default: rf_wen = 4'b0001;
                endcase
            end
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Latches the execute-stage bus, aligns
// synchronous SRAM load data, and holds that read data while writeback is
// back-pressuring (the SRAM output is only valid for one cycle).
// Optional feature macro: MEM_STAGE_FWD_LOAD_EN -- when defined, aligned load
// results (except lwl/lwr) are forwarded to decode; otherwise loads are not
// forwarded from this stage.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
    output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
    input  logic [DATA_W-1:0]          data_sram_rdata
);

    es_to_ms_t         bus_q, bus_d;
    logic              ms_valid_q, ms_valid_d;
    logic              rdata_buf_valid_q, rdata_buf_valid_d;
    logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;

    logic              ms_ready_go;
    logic [DATA_W-1:0] rdata_eff;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        ld_rf_wen;
    logic [DATA_W-1:0] final_result;
    logic              fwd_valid;
    ms_to_ws_t         ms_to_ws;
    logic              unused_ld_extd_op;

    // Handshake: this stage never stalls on its own
    always_comb begin
        ms_ready_go    = 1'b1;
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
    end

    // Next-state for valid, bus register and read-data hold buffer
    always_comb begin
        ms_valid_d        = ms_valid_q;
        bus_d             = bus_q;
        rdata_buf_valid_d = rdata_buf_valid_q;
        rdata_buf_d       = rdata_buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_to_ms_bus;
        end
        // Capture the one-cycle SRAM data the first time writeback refuses it
        if (ms_allowin) begin
            rdata_buf_valid_d = 1'b0;
        end else if (ms_valid_q && !rdata_buf_valid_q && !ws_allowin) begin
            rdata_buf_valid_d = 1'b1;
            rdata_buf_d       = data_sram_rdata;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q        <= 1'b0;
            rdata_buf_valid_q <= 1'b0;
        end else begin
            ms_valid_q        <= ms_valid_d;
            rdata_buf_valid_q <= rdata_buf_valid_d;
        end
    end

    // Datapath registers; contents are qualified by the valid flags
    always_ff @(posedge clk) begin
        bus_q       <= bus_d;
        rdata_buf_q <= rdata_buf_d;
    end

    assign rdata_eff = rdata_buf_valid_q ? rdata_buf_q : data_sram_rdata;

    mem_stage_ld_align u_ld_align (
        .inst_load (bus_q.inst_load),
        .addr      (bus_q.alu_result[1:0]),
        .rdata     (rdata_eff),
        .gr_we     (bus_q.gr_we),
        .ld_data   (ld_data),
        .rf_wen    (ld_rf_wen)
    );

    // Result select, forward qualification and output bus packing
    always_comb begin
        final_result = bus_q.res_from_mem ? ld_data : bus_q.alu_result;
`ifdef MEM_STAGE_FWD_LOAD_EN
        fwd_valid = ms_valid_q && !(bus_q.inst_load[LD_LWL] | bus_q.inst_load[LD_LWR]);
`else
        fwd_valid = ms_valid_q && !bus_q.res_from_mem;
`endif
        ms_to_ws.rf_wen       = ld_rf_wen & {4{ms_valid_q}};
        ms_to_ws.dest         = bus_q.dest;
        ms_to_ws.final_result = final_result;
        ms_to_ws.pc           = bus_q.pc;
    end

    assign ms_to_ws_bus   = ms_to_ws;
    // dest is masked so the stall bus reads zero whenever the stage is empty
    assign stall_ms_bus   = {{5{ms_valid_q && bus_q.gr_we}}, bus_q.dest & {5{ms_valid_q}}};
    assign forward_ms_bus = {fwd_valid, final_result};

    // Extension opcode is consumed upstream; it only rides along here
    assign unused_ld_extd_op = ^bus_q.ld_extd_op;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven load alignment vectors plus hand-written
// back-pressure, back-to-back and reset sequences, checked via a scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [82:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [72:0] ms_to_ws_bus;
    logic [9:0]  stall_ms_bus;
    logic [32:0] forward_ms_bus;
    logic [31:0] data_sram_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [72:0] bus;
        logic [32:0] fwd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [6:0]  ld;
        logic        rfm;
        logic        gr_we;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] res;
        logic [3:0]  wen;
    } vec_t;
    vec_t vecs[17];

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .stall_ms_bus    (stall_ms_bus),
        .forward_ms_bus  (forward_ms_bus),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic exp_fwd(input logic [6:0] ld, input logic rfm);
`ifdef MEM_STAGE_FWD_LOAD_EN
        return !(ld[1] | ld[0]);
`else
        return !rfm;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction from execute and record what writeback must see
    task automatic issue(input logic [6:0] ld, input logic rfm, input logic gr_we,
                         input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] res, input logic [3:0] wen);
        exp_t e;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {rfm, ld, 5'b10101, gr_we, dest, alu, pc};
        e.bus = {wen, dest, res, pc};
        e.fwd = {exp_fwd(ld, rfm), res};
        sb.push_back(e);
    endtask

    // Writeback side: every accepted output is checked against the scoreboard
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%0h required=none", ms_to_ws_bus);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ms_to_ws_bus", 128'(ms_to_ws_bus), 128'(e.bus));
                chk("forward_ms_bus", 128'(forward_ms_bus), 128'(e.fwd));
            end
        end
    end

    initial begin
        vecs[0]  = '{7'b0100000, 1'b1, 1'b1, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1111};
        vecs[1]  = '{7'b0010000, 1'b1, 1'b1, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080, 4'b1111};
        vecs[2]  = '{7'b0100000, 1'b1, 1'b1, 32'h0000_0101, 32'h80FF_1234, 32'h0000_0012, 4'b1111};
        vecs[3]  = '{7'b0010000, 1'b1, 1'b1, 32'h0000_0102, 32'h80FF_1234, 32'h0000_00FF, 4'b1111};
        vecs[4]  = '{7'b0000100, 1'b1, 1'b1, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001, 4'b1111};
        vecs[5]  = '{7'b0001000, 1'b1, 1'b1, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001, 4'b1111};
        vecs[6]  = '{7'b0001000, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_ABCD, 32'hFFFF_ABCD, 4'b1111};
        vecs[7]  = '{7'b0000010, 1'b1, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100};
        vecs[8]  = '{7'b0000001, 1'b1, 1'b1, 32'h0000_0102, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011};
        vecs[9]  = '{7'b0000010, 1'b1, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 32'hDD00_0000, 4'b1000};
        vecs[10] = '{7'b0000010, 1'b1, 1'b1, 32'h0000_0102, 32'hAABB_CCDD, 32'hBBCC_DD00, 4'b1110};
        vecs[11] = '{7'b0000010, 1'b1, 1'b1, 32'h0000_0103, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111};
        vecs[12] = '{7'b0000001, 1'b1, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111};
        vecs[13] = '{7'b0000001, 1'b1, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'h00AA_BBCC, 4'b0111};
        vecs[14] = '{7'b0000001, 1'b1, 1'b1, 32'h0000_0103, 32'hAABB_CCDD, 32'h0000_00AA, 4'b0001};
        vecs[15] = '{7'b1000000, 1'b1, 1'b1, 32'h0000_0102, 32'h1234_5678, 32'h1234_5678, 4'b1111};
        vecs[16] = '{7'b0000000, 1'b0, 1'b0, 32'h0000_1230, 32'hFFFF_FFFF, 32'h0000_1230, 4'b0000};

        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ms_to_ws_valid", 128'(ms_to_ws_valid), 128'd0);
        chk("rst_stall_ms_bus", 128'(stall_ms_bus), 128'd0);
        chk("rst_fwd_valid", 128'(forward_ms_bus[32]), 128'd0);
        chk("rst_ms_allowin", 128'(ms_allowin), 128'd1);

        // Alignment table: one instruction at a time, one output cycle each
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].ld, vecs[i].rfm, vecs[i].gr_we, 5'(i + 1), vecs[i].alu,
                  32'h1000 + 32'(i * 4), vecs[i].res, vecs[i].wen);
            step();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            @(negedge clk);
            chk("vec_valid_hi", 128'(ms_to_ws_valid), 128'd1);
            step();
            @(negedge clk);
            chk("vec_valid_lo", 128'(ms_to_ws_valid), 128'd0);
        end

        // lw held across three cycles of writeback back-pressure
        issue(7'b1000000, 1'b1, 1'b1, 5'd9, 32'h0000_0200, 32'h2000, 32'h1234_5678, 4'b1111);
        step();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("hold_allowin_0", 128'(ms_allowin), 128'd0);
        chk("hold_result_0", 128'(ms_to_ws_bus[63:32]), 128'h1234_5678);
        chk("hold_fwd_load", 128'(forward_ms_bus[32]), 128'(exp_fwd(7'b1000000, 1'b1)));
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("hold_allowin", 128'(ms_allowin), 128'd0);
            chk("hold_result", 128'(ms_to_ws_bus[63:32]), 128'h1234_5678);
            chk("hold_valid", 128'(ms_to_ws_valid), 128'd1);
            step();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("release_allowin", 128'(ms_allowin), 128'd1);
        step();
        @(negedge clk);
        chk("release_valid_lo", 128'(ms_to_ws_valid), 128'd0);

        // Back-to-back ALU results, no bubbles
        issue(7'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'h3000, 32'd1, 4'b1111);
        step();
        issue(7'b0, 1'b0, 1'b1, 5'd2, 32'd2, 32'h3004, 32'd2, 4'b1111);
        @(negedge clk);
        chk("b2b_valid_1", 128'(ms_to_ws_valid), 128'd1);
        step();
        issue(7'b0, 1'b0, 1'b1, 5'd3, 32'd3, 32'h3008, 32'd3, 4'b1111);
        @(negedge clk);
        chk("b2b_valid_2", 128'(ms_to_ws_valid), 128'd1);
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid_3", 128'(ms_to_ws_valid), 128'd1);
        step();
        @(negedge clk);
        chk("b2b_valid_end", 128'(ms_to_ws_valid), 128'd0);

        // Reset while a stalled load is held
        issue(7'b0100000, 1'b1, 1'b1, 5'd7, 32'h0000_0300, 32'h4000, 32'h0000_0011, 4'b1111);
        step();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h0000_0011;
        @(negedge clk);
        chk("stall_bus_load", 128'(stall_ms_bus), 128'({5'h1F, 5'd7}));
        chk("stall_fwd_load", 128'(forward_ms_bus[32]), 128'(exp_fwd(7'b0100000, 1'b1)));
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_valid", 128'(ms_to_ws_valid), 128'd0);
        chk("post_rst_stall", 128'(stall_ms_bus), 128'd0);
        chk("post_rst_fwd", 128'(forward_ms_bus[32]), 128'd0);
        chk("post_rst_allowin", 128'(ms_allowin), 128'd1);
        ws_allowin = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_still_idle", 128'(ms_to_ws_valid), 128'd0);

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
